imem_pipe: RTL



---
 rtl/imem_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/imem_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : imem_pipe
// Description : Read-only instruction memory for the fetch stage. Fixed
//               response latency, up to MAX_OUTSTANDING in-flight requests,
//               in-order responses with error flag and fetch flush/redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_pipe #(
    parameter int LAT             = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DEPTH_WORDS     = 4096
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        flush_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_addr_o,
    output logic [31:0] rsp_instr_o,
    output logic        rsp_err_o
);

    localparam int AW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [AW-1:0] AGE_MAX  = AW'(LAT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    // Memory is read-only, so its contents are expressed as a lookup function.
    // Without the DPI loader the fill pattern is mem[i] = i + 0x1000.
    function automatic logic [31:0] rom_word(input logic [29:0] idx);
        return {2'b00, idx} + 32'h0000_1000;
    endfunction

    // Circular-buffer pointer advance; depth need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Entry storage, indexed by physical slot.
    logic [31:0]   addr_q  [MAX_OUTSTANDING];
    logic [31:0]   addr_d  [MAX_OUTSTANDING];
    logic [31:0]   instr_q [MAX_OUTSTANDING];
    logic [31:0]   instr_d [MAX_OUTSTANDING];
    logic          err_q   [MAX_OUTSTANDING];
    logic          err_d   [MAX_OUTSTANDING];
    logic [AW-1:0] age_q   [MAX_OUTSTANDING];
    logic [AW-1:0] age_d   [MAX_OUTSTANDING];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Last presented head values, shown while no response is valid.
    logic [31:0]   hold_addr_q, hold_addr_d;
    logic [31:0]   hold_instr_q, hold_instr_d;
    logic          hold_err_q, hold_err_d;

    logic          w_accept;
    logic          w_pop;
    logic [29:0]   w_req_idx;
    logic          w_req_err;
    logic [31:0]   w_req_instr;

    // Ready depends on registered occupancy only; a same-cycle pop does not help.
    assign req_ready_o = (count_q < CNT_MAX);
    assign rsp_valid_o = (count_q != '0) && (age_q[head_q] == AGE_MAX);

    assign w_accept    = req_valid_i && req_ready_o;
    assign w_pop       = rsp_valid_o && rsp_ready_i;

    assign w_req_idx   = req_addr_i[31:2];
    // Out-of-range indices are flagged, never wrapped into the array.
    assign w_req_err   = (req_addr_i[1:0] != 2'b00) ||
                         ({2'b00, w_req_idx} >= 32'(DEPTH_WORDS));
    assign w_req_instr = w_req_err ? 32'h0 : rom_word(w_req_idx);

    assign rsp_addr_o  = rsp_valid_o ? addr_q[head_q]  : hold_addr_q;
    assign rsp_instr_o = rsp_valid_o ? instr_q[head_q] : hold_instr_q;
    assign rsp_err_o   = rsp_valid_o ? err_q[head_q]   : hold_err_q;

    // Next-state: aging, push at tail, pop at head, flush with redirect.
    always_comb begin
        addr_d       = addr_q;
        instr_d      = instr_q;
        err_d        = err_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        hold_addr_d  = hold_addr_q;
        hold_instr_d = hold_instr_q;
        hold_err_d   = hold_err_q;

        // Every slot ages; stale slots are harmless because they are never read
        // as head until rewritten with age 0.
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + 1'b1;
        end

        if (flush_i) begin
            // Everything in flight is dropped; a request accepted this cycle
            // becomes the sole entry.
            head_d  = tail_q;
            tail_d  = w_accept ? ptr_inc(tail_q) : tail_q;
            count_d = w_accept ? CW'(1) : '0;
        end else begin
            head_d  = w_pop    ? ptr_inc(head_q) : head_q;
            tail_d  = w_accept ? ptr_inc(tail_q) : tail_q;
            count_d = count_q + CW'(w_accept) - CW'(w_pop);
        end

        if (w_accept) begin
            addr_d[tail_q]  = req_addr_i;
            instr_d[tail_q] = w_req_instr;
            err_d[tail_q]   = w_req_err;
            age_d[tail_q]   = '0;
        end

        if (rsp_valid_o) begin
            hold_addr_d  = addr_q[head_q];
            hold_instr_d = instr_q[head_q];
            hold_err_d   = err_q[head_q];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                addr_q[i]  <= '0;
                instr_q[i] <= '0;
                err_q[i]   <= 1'b0;
                age_q[i]   <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            hold_addr_q  <= '0;
            hold_instr_q <= '0;
            hold_err_q   <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            err_q        <= err_d;
            age_q        <= age_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            hold_addr_q  <= hold_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_err_q   <= hold_err_d;
        end
    end

endmodule
`default_nettype wire
